// File: rtl/rx_burst_scheduler.sv
// rx_burst_scheduler: issues fixed-length DDR write bursts into a ring buffer,
// tracking outstanding bursts, committed occupation and consumer releases.
module rx_burst_scheduler #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned BEAT_BYTES      = 16
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cfg_enable,
  input  logic        cfg_start_trigger,
  input  logic        cfg_single_loop,
  input  logic [47:0] cfg_base_addr,
  input  logic [31:0] cfg_buffer_size,
  input  logic [8:0]  cfg_burst_length,
  input  logic [31:0] cfg_burst_count,
  input  logic [15:0] fifo_level,
  input  logic        fifo_full,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [47:0] cmd_addr,
  output logic [7:0]  cmd_len,
  input  logic        done_pulse,
  input  logic        rel_pulse,
  input  logic [16:0] rel_bytes,
  output logic        start_ack,
  output logic        busy,
  output logic [31:0] buffer_occupation,
  output logic        buffer_full,
  output logic        buffer_empty,
  output logic        buffer_overflow,
  output logic [31:0] overflow_count,
  output logic [31:0] burst_count_total
);

  typedef enum logic [2:0] {IDLE, ARMED, RUN, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [47:0] base_q;
  logic [31:0] size_q;
  logic [8:0]  blen_q;
  logic [7:0]  len_m1_q;
  logic [31:0] bcount_q;
  logic        single_q;
  logic [31:0] offset_q;
  logic [3:0]  outstanding_q;
  logic [31:0] issued_q;
  logic [31:0] total_q;
  logic [31:0] occ_q;
  logic [31:0] ovf_cnt_q;
  logic        ovf_flag_q;
  logic        cmd_valid_q;

  logic [12:0] burst_bytes;
  logic [16:0] inflight;
  logic        space_ok, fifo_ok, out_ok, cnt_ok, single_done, run_exit;
  logic        set_valid, handshake, done_ok, ovf_inc;
  logic [32:0] off_inc;
  logic        off_wrap;
  logic [32:0] occ_add;
  logic [31:0] occ_next;

  assign burst_bytes = 13'(32'(blen_q) * BEAT_BYTES);
  assign inflight    = 17'(outstanding_q) * 17'(burst_bytes);

  // Space accounts for committed bytes plus bursts still in flight.
  assign space_ok    = (34'(occ_q) + 34'(inflight) + 34'(burst_bytes)) <= 34'(size_q);
  assign fifo_ok     = fifo_level >= 16'(blen_q);
  assign out_ok      = 32'(outstanding_q) < MAX_OUTSTANDING;
  assign cnt_ok      = !single_q || (issued_q < bcount_q);
  assign single_done = single_q && (issued_q == bcount_q);
  assign run_exit    = !cfg_enable || single_done;

  // cmd_valid is registered and only cleared by its handshake, which keeps
  // address/length stable and lets a pending command finish before DRAIN.
  assign set_valid = (state_q == RUN) && !cmd_valid_q && !run_exit &&
                     fifo_ok && out_ok && space_ok && cnt_ok;
  assign handshake = cmd_valid_q && cmd_ready;
  assign done_ok   = done_pulse && (outstanding_q != '0);

  assign off_inc  = 33'(offset_q) + 33'(burst_bytes);
  assign off_wrap = (off_inc + 33'(burst_bytes)) > 33'(size_q);

  // Completion is added before the release is subtracted so a matched
  // done/release pair leaves occupation unchanged even from zero.
  assign occ_add  = 33'(occ_q) + (done_ok ? 33'(burst_bytes) : '0);
  assign occ_next = rel_pulse ? ((occ_add > 33'(rel_bytes)) ? 32'(occ_add - 33'(rel_bytes)) : '0)
                              : occ_add[31:0];

  assign buffer_full  = (33'(occ_q) + 33'(burst_bytes)) > 33'(size_q);
  assign buffer_empty = (occ_q == '0);
  assign ovf_inc      = (state_q == RUN) && fifo_full && buffer_full && (ovf_cnt_q != '1);

  assign cmd_valid         = cmd_valid_q;
  assign cmd_addr          = base_q + 48'(offset_q);
  assign cmd_len           = len_m1_q;
  assign busy              = (state_q != IDLE);
  assign buffer_occupation = occ_q;
  assign buffer_overflow   = ovf_flag_q;
  assign overflow_count    = ovf_cnt_q;
  assign burst_count_total = total_q;

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and the start acknowledge pulse.
  always_comb begin
    state_d   = state_q;
    start_ack = 1'b0;
    case (state_q)
      IDLE:  if (cfg_enable) state_d = ARMED;
      ARMED: begin
        if (!cfg_enable) state_d = IDLE;
        else if (cfg_start_trigger) begin
          state_d   = RUN;
          start_ack = 1'b1;
        end
      end
      RUN:   if (run_exit && !cmd_valid_q) state_d = DRAIN;
      DRAIN: begin
        if (outstanding_q == '0) begin
          if (single_done)      state_d = DONE;
          else if (!cfg_enable) state_d = IDLE;
        end
      end
      DONE:    if (!cfg_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Run configuration latch, issue/complete bookkeeping and status counters.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      base_q        <= '0;
      size_q        <= '0;
      blen_q        <= '0;
      len_m1_q      <= '0;
      bcount_q      <= '0;
      single_q      <= 1'b0;
      offset_q      <= '0;
      outstanding_q <= '0;
      issued_q      <= '0;
      total_q       <= '0;
      occ_q         <= '0;
      ovf_cnt_q     <= '0;
      ovf_flag_q    <= 1'b0;
      cmd_valid_q   <= 1'b0;
    end else if (start_ack) begin
      base_q        <= cfg_base_addr;
      size_q        <= cfg_buffer_size;
      blen_q        <= cfg_burst_length;
      len_m1_q      <= 8'(cfg_burst_length - 9'd1);
      bcount_q      <= cfg_burst_count;
      single_q      <= cfg_single_loop;
      offset_q      <= '0;
      outstanding_q <= '0;
      issued_q      <= '0;
      total_q       <= '0;
      occ_q         <= '0;
      ovf_cnt_q     <= '0;
      ovf_flag_q    <= 1'b0;
      cmd_valid_q   <= 1'b0;
    end else begin
      if (set_valid)      cmd_valid_q <= 1'b1;
      else if (handshake) cmd_valid_q <= 1'b0;
      if (handshake) begin
        issued_q <= issued_q + 32'd1;
        offset_q <= off_wrap ? '0 : off_inc[31:0];
      end
      if (handshake && !done_ok)      outstanding_q <= outstanding_q + 4'd1;
      else if (!handshake && done_ok) outstanding_q <= outstanding_q - 4'd1;
      if (done_ok) total_q <= total_q + 32'd1;
      occ_q <= occ_next;
      if (ovf_inc) begin
        ovf_cnt_q  <= ovf_cnt_q + 32'd1;
        ovf_flag_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rx_burst_scheduler.md
RX_BURST_SCHEDULER -- requirements
Module: rx_burst_scheduler

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the limit on issued-but-uncompleted bursts (1..15).
REQ-002 SHALL have parameter BEAT_BYTES, default 16, meaning bytes per data beat (128-bit).
REQ-003 SHALL use one clock and an asynchronous, active-high reset; no other clock or reset exists.
REQ-004 aclk  in  1  sole clock; all state changes on its rising edge.
REQ-005 areset  in  1  asynchronous active-high reset.
REQ-006 cfg_enable  in  1  run enable.
REQ-007 cfg_start_trigger  in  1  level start request.
REQ-008 cfg_single_loop  in  1  stop after cfg_burst_count bursts.
REQ-009 cfg_base_addr  in  48  ring base byte address in DDR.
REQ-010 cfg_buffer_size  in  32  ring size in bytes.
REQ-011 cfg_burst_length  in  9  beats per burst, 1..256.
REQ-012 cfg_burst_count  in  32  bursts per single-loop run.
REQ-013 fifo_level  in  16  beats available in the upstream stream FIFO.
REQ-014 fifo_full  in  1  upstream FIFO full.
REQ-015 cmd_valid / cmd_ready  out / in  1 / 1  burst command handshake to the write datamover.
REQ-016 cmd_addr  out  48  burst start byte address.
REQ-017 cmd_len  out  8  AXI-style beats minus 1.
REQ-018 done_pulse  in  1  one burst fully written (write response received).
REQ-019 rel_pulse / rel_bytes  in / in  1 / 17  consumer released rel_bytes from the ring.
REQ-020 start_ack  out  1  one-cycle pulse on run start.
REQ-021 busy  out  1  state is not IDLE.
REQ-022 buffer_occupation  out  32  committed, unreleased bytes.
REQ-023 buffer_full / buffer_empty / buffer_overflow  out  1 each  status flags.
REQ-024 overflow_count  out  32  cycles with fifo_full high while issue is blocked by buffer_full.
REQ-025 burst_count_total  out  32  completed bursts in the current run.

Function
REQ-026 SHALL implement states IDLE, ARMED, RUN, DRAIN, DONE.
REQ-027 IDLE->ARMED when cfg_enable=1; ARMED->RUN when cfg_start_trigger=1, pulsing start_ack for that cycle; ARMED->IDLE when cfg_enable=0.
REQ-028 On entry to RUN, SHALL latch base, size, burst_length, burst_count and single_loop, zero the write offset, outstanding count, burst_count_total, occupation and the issued count; cfg changes during RUN/DRAIN are ignored.
REQ-029 burst_bytes = burst_length * BEAT_BYTES, 13-bit unsigned.
REQ-030 In RUN, SHALL raise cmd_valid only when fifo_level >= burst_length, outstanding < MAX_OUTSTANDING, occupation + inflight_bytes + burst_bytes <= size, and (single_loop=0 or issued < burst_count).
REQ-031 cmd_addr = base + offset and cmd_len = burst_length-1; both are held stable while cmd_valid=1 and cmd_ready=0.
REQ-032 On cmd_valid & cmd_ready: outstanding+1, issued+1, offset += burst_bytes; if the new offset + burst_bytes > size, offset SHALL wrap to 0.
REQ-033 On done_pulse: outstanding-1, burst_count_total+1, occupation += burst_bytes; done_pulse with outstanding=0 SHALL be ignored.
REQ-034 On rel_pulse: occupation -= rel_bytes, saturating at 0; simultaneous done and release SHALL apply both in the same cycle.
REQ-035 A simultaneous issue and done SHALL leave outstanding unchanged.
REQ-036 buffer_full=1 when occupation + burst_bytes > size; buffer_empty=1 when occupation = 0; buffer_overflow is sticky per run, set on the first overflow_count increment.
REQ-037 RUN->DRAIN when cfg_enable=0, or when single_loop=1 and issued = burst_count.
REQ-038 A pending cmd_valid SHALL complete its handshake before the RUN->DRAIN transition is taken.
REQ-039 DRAIN->DONE when outstanding = 0 and the run was single-loop complete; DRAIN->IDLE when outstanding = 0 and cfg_enable=0.
REQ-040 DONE->IDLE when cfg_enable=0.
REQ-041 overflow_count SHALL saturate at 0xFFFFFFFF.

Reset
REQ-042 While areset=1, SHALL set state IDLE and drive all outputs to 0, asynchronously; counters, offset and flags clear, except buffer_empty=1.
REQ-043 Reset asserted mid-burst SHALL drop all outstanding tracking; no recovery of in-flight bursts is attempted.

Verification
REQ-044 base=0x8_0000_0000, size=0x2000, len=128, count=4, single_loop=1, fifo_level=1024, cmd_ready=1, done one cycle after each issue -> addresses 0x8_0000_0000, +0x800, +0x1000, +0x1800; cmd_len=127; burst_count_total=4; final state DONE.
REQ-045 size=0x1800, len=128, single_loop=0, continuous release -> address sequence 0, 0x800, 0x1000, 0 (wrap).
REQ-046 No done_pulse, MAX_OUTSTANDING=4 -> exactly 4 handshakes, then cmd_valid=0.
REQ-047 size=0x1000, no release, fifo_full=1 -> 2 bursts complete, buffer_full=1, overflow_count increments each cycle, buffer_overflow=1.
REQ-048 cfg_enable dropped with 3 outstanding -> no new cmd, stays DRAIN until 3 done_pulse, then IDLE.
REQ-049 Simultaneous done_pulse and rel_pulse (rel_bytes=0x800, len=128) -> occupation unchanged.
